// File: rtl/hazard_control_unit_if.sv
// Control bundle between the pipeline core (master) and the hazard control unit (slave).
// Carries hazard inputs, pipeline register controls, FSM state and performance counters.
interface hazard_control_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd_addr;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             perf_clear;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             mem_freeze;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       fsm_state;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output ex_mem_read, ex_rd_addr, ex_branch_taken,
        output mem_req, mem_ready, perf_clear,
        input  pc_write, if_id_write, if_id_flush, id_ex_stall, mem_freeze,
        input  stall_cycles, flush_count, fsm_state
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  ex_mem_read, ex_rd_addr, ex_branch_taken,
        input  mem_req, mem_ready, perf_clear,
        output pc_write, if_id_write, if_id_flush, id_ex_stall, mem_freeze,
        output stall_cycles, flush_count, fsm_state
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard control: load-use bubbles, branch flush and data-memory freeze for IF/ID, ID/EX and PC.
// Controls are combinational from registered state; a mem wait parks the FSM and resumes it on mem_ready.
module hazard_control_unit #(
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave hz
);
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_LU_STALL = 2'b01;
    localparam logic [1:0] ST_MEM_WAIT = 2'b10;

    localparam logic [3:0] LU_RELOAD = 4'(LOAD_LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       saved_q, saved_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       lu;
    logic       mw;
    logic [1:0] eff_state;
    logic       pc_write_c, if_id_write_c, if_id_flush_c, id_ex_stall_c, mem_freeze_c;
    logic       pc_write_o, if_id_write_o, if_id_flush_o, id_ex_stall_o, mem_freeze_o;
    logic       stall_inc;

    always_comb begin
        lu = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
             ((hz.id_uses_rs1 && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
              (hz.id_uses_rs2 && (hz.id_rs2_addr == hz.ex_rd_addr)));
        mw = hz.mem_req && !hz.mem_ready;
    end

    // On the mem_ready cycle the parked state acts as if it were current, so it
    // drives outputs and advances exactly as it would have without the wait.
    always_comb begin
        state_d       = state_q;
        saved_d       = saved_q;
        cnt_d         = cnt_q;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_stall_c = 1'b0;
        mem_freeze_c  = 1'b0;

        eff_state = ((state_q == ST_MEM_WAIT) && hz.mem_ready) ? saved_q : state_q;

        if (eff_state == ST_MEM_WAIT) begin
            mem_freeze_c  = 1'b1;
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
        end else if (mw) begin
            mem_freeze_c  = 1'b1;
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            saved_d       = eff_state;
            state_d       = ST_MEM_WAIT;
        end else if (eff_state == ST_LU_STALL) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_stall_c = 1'b1;
            cnt_d         = cnt_q - 4'd1;
            state_d       = (cnt_q == 4'd1) ? ST_RUN : ST_LU_STALL;
        end else if (hz.ex_branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_stall_c = 1'b1;
            state_d       = ST_RUN;
        end else if (lu) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_stall_c = 1'b1;
            if (LOAD_LATENCY > 1) begin
                state_d = ST_LU_STALL;
                cnt_d   = LU_RELOAD;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        pc_write_o    = !rst && pc_write_c;
        if_id_write_o = !rst && if_id_write_c;
        if_id_flush_o = !rst && if_id_flush_c;
        id_ex_stall_o = !rst && id_ex_stall_c;
        mem_freeze_o  = !rst && mem_freeze_c;
        stall_inc     = (id_ex_stall_o && !if_id_flush_o) || mem_freeze_o;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.perf_clear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (if_id_flush_o && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            saved_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_write     = pc_write_o;
    assign hz.if_id_write  = if_id_write_o;
    assign hz.if_id_flush  = if_id_flush_o;
    assign hz.id_ex_stall  = id_ex_stall_o;
    assign hz.mem_freeze   = mem_freeze_o;
    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_count  = flush_cnt_q;
    assign hz.fsm_state    = state_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (1-cycle and 3-cycle load latency, wide and 4-bit counters)
// share stimulus and are checked every cycle against a bubbles-owed reference model.
module tb_hazard_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mrd, br, mreq, mrdy, pclr;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_control_unit_if #(.CNT_W(32)) h1 ();
    hazard_control_unit_if #(.CNT_W(4))  h3 ();

    hazard_control_unit #(.LOAD_LATENCY(1), .CNT_W(32)) u_ll1 (.clk(clk), .rst(rst), .hz(h1));
    hazard_control_unit #(.LOAD_LATENCY(3), .CNT_W(4))  u_ll3 (.clk(clk), .rst(rst), .hz(h3));

    assign h1.id_rs1_addr = rs1;  assign h3.id_rs1_addr = rs1;
    assign h1.id_rs2_addr = rs2;  assign h3.id_rs2_addr = rs2;
    assign h1.id_uses_rs1 = use1; assign h3.id_uses_rs1 = use1;
    assign h1.id_uses_rs2 = use2; assign h3.id_uses_rs2 = use2;
    assign h1.ex_mem_read = mrd;  assign h3.ex_mem_read = mrd;
    assign h1.ex_rd_addr  = rd;   assign h3.ex_rd_addr  = rd;
    assign h1.ex_branch_taken = br;   assign h3.ex_branch_taken = br;
    assign h1.mem_req     = mreq; assign h3.mem_req     = mreq;
    assign h1.mem_ready   = mrdy; assign h3.mem_ready   = mrdy;
    assign h1.perf_clear  = pclr; assign h3.perf_clear  = pclr;

    logic [4:0]  dut_ctl [2];
    logic [1:0]  dut_st  [2];
    logic [31:0] dut_sc  [2];
    logic [31:0] dut_fc  [2];

    assign dut_ctl[0] = {h1.pc_write, h1.if_id_write, h1.if_id_flush, h1.id_ex_stall, h1.mem_freeze};
    assign dut_ctl[1] = {h3.pc_write, h3.if_id_write, h3.if_id_flush, h3.id_ex_stall, h3.mem_freeze};
    assign dut_st[0]  = h1.fsm_state;
    assign dut_st[1]  = h3.fsm_state;
    assign dut_sc[0]  = h1.stall_cycles;
    assign dut_sc[1]  = 32'(h3.stall_cycles);
    assign dut_fc[0]  = h1.flush_count;
    assign dut_fc[1]  = 32'(h3.flush_count);

    // Reference model: bubbles still owed, whether a memory wait is pending, counter values.
    int      owed    [2] = '{0, 0};
    bit      waiting [2] = '{0, 0};
    longint  m_sc    [2] = '{0, 0};
    longint  m_fc    [2] = '{0, 0};
    int      lat     [2] = '{1, 3};
    longint  cmax    [2] = '{64'hFFFF_FFFF, 64'd15};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_check(input int k);
        logic [4:0] exp_ctl;
        logic [1:0] exp_st;
        bit lu_m, mw_m, stall_ev, flush_ev;
        if (rst) begin
            owed[k] = 0; waiting[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
        end
        exp_st = waiting[k] ? 2'd2 : ((owed[k] > 0) ? 2'd1 : 2'd0);
        check_eq($sformatf("u%0d.fsm_state", k), 64'(dut_st[k]), 64'(exp_st));
        check_eq($sformatf("u%0d.stall_cycles", k), 64'(dut_sc[k]), 64'(m_sc[k]));
        check_eq($sformatf("u%0d.flush_count", k), 64'(dut_fc[k]), 64'(m_fc[k]));

        lu_m = mrd && (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        mw_m = mreq && !mrdy;
        if (rst) begin
            exp_ctl = 5'b00000;
        end else if (waiting[k] && !mrdy) begin
            exp_ctl = 5'b00001;
        end else if (!waiting[k] && mw_m) begin
            exp_ctl = 5'b00001;
            waiting[k] = 1'b1;
        end else begin
            waiting[k] = 1'b0;
            if (owed[k] > 0) begin
                exp_ctl = 5'b00010;
                owed[k] = owed[k] - 1;
            end else if (br) begin
                exp_ctl = 5'b11110;
            end else if (lu_m) begin
                exp_ctl = 5'b00010;
                owed[k] = lat[k] - 1;
            end else begin
                exp_ctl = 5'b11000;
            end
        end
        check_eq($sformatf("u%0d.ctl{pw,iw,fl,st,fz}", k), 64'(dut_ctl[k]), 64'(exp_ctl));

        if (!rst) begin
            stall_ev = (exp_ctl[1] && !exp_ctl[2]) || exp_ctl[0];
            flush_ev = exp_ctl[2];
            if (pclr) begin
                m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                if (stall_ev && m_sc[k] < cmax[k]) m_sc[k] = m_sc[k] + 1;
                if (flush_ev && m_fc[k] < cmax[k]) m_fc[k] = m_fc[k] + 1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_check(k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; use1 = 1'b0; use2 = 1'b0;
        mrd = 1'b0; br = 1'b0; mreq = 1'b0; mrdy = 1'b1; pclr = 1'b0;
    endtask

    task automatic lu_hit(input logic [4:0] r);
        mrd = 1'b1; rd = r; rs1 = 5'd5; use1 = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        step();
        step();
        rst = 1'b0;
        step();

        // Load-use on x5; LL=1 gives one bubble, LL=3 gives three.
        lu_hit(5'd5); step();
        idle(); step(); step(); step();
        check_eq("t1_ll1_stall_cycles", 64'(dut_sc[0]), 64'd1);
        check_eq("t2_ll3_stall_cycles", 64'(dut_sc[1]), 64'd3);

        // rd = x0 never stalls.
        lu_hit(5'd0); step();
        idle(); step();
        check_eq("t2_rd0_no_stall", 64'(dut_sc[0]), 64'd1);

        // Taken branch overrides a load-use hit.
        pclr = 1'b1; step();
        idle(); br = 1'b1; lu_hit(5'd5); step();
        idle(); step();
        check_eq("t3_flush_count", 64'(dut_fc[0]), 64'd1);
        check_eq("t3_stall_cycles", 64'(dut_sc[0]), 64'd0);
        check_eq("t3_ll3_stall_cycles", 64'(dut_sc[1]), 64'd0);

        // Memory wait of 4 cycles while LL=3 unit sits in LU_STALL with one bubble left.
        pclr = 1'b1; step();
        idle(); lu_hit(5'd5); step();
        idle(); step();
        check_eq("t4_state_lu_stall", 64'(dut_st[1]), 64'd1);
        mreq = 1'b1; mrdy = 1'b0;
        for (int i = 0; i < 4; i++) step();
        mrdy = 1'b1; step();
        idle(); step(); step();
        check_eq("t4_ll3_stall_cycles", 64'(dut_sc[1]), 64'd7);
        check_eq("t4_ll1_stall_cycles", 64'(dut_sc[0]), 64'd5);
        check_eq("t4_ll3_state_run", 64'(dut_st[1]), 64'd0);

        // Saturate the 4-bit counter, then clear alongside an increment.
        mreq = 1'b1; mrdy = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check_eq("t5_saturated", 64'(dut_sc[1]), 64'd15);
        step();
        check_eq("t5_saturated_hold", 64'(dut_sc[1]), 64'd15);
        pclr = 1'b1; step();
        check_eq("t5_clear_ll3", 64'(dut_sc[1]), 64'd0);
        check_eq("t5_clear_ll1", 64'(dut_sc[0]), 64'd0);
        pclr = 1'b0; mrdy = 1'b1; step();
        idle(); step();

        // Reset in the middle of a multi-cycle load-use stall.
        lu_hit(5'd5); step();
        idle();
        check_eq("t6_state_before_rst", 64'(dut_st[1]), 64'd1);
        rst = 1'b1;
        step();
        check_eq("t6_state_in_rst", 64'(dut_st[1]), 64'd0);
        check_eq("t6_stall_in_rst", 64'(dut_sc[1]), 64'd0);
        rst = 1'b0;
        step();
        check_eq("t6_no_residual_bubble", 64'(dut_sc[1]), 64'd0);
        check_eq("t6_state_after", 64'(dut_st[1]), 64'd0);

        // Randomized traffic over a small register window to make hazards frequent.
        for (int i = 0; i < 3000; i++) begin
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 3));
            use1 = 1'($urandom_range(0, 1));
            use2 = 1'($urandom_range(0, 1));
            mrd  = 1'($urandom_range(0, 1));
            br   = ($urandom_range(0, 6) == 0);
            mreq = ($urandom_range(0, 3) == 0);
            mrdy = 1'($urandom_range(0, 1));
            pclr = ($urandom_range(0, 49) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
